// File: rtl/usb_tx_sequencer.sv
// -----------------------------------------------------------------------------
// usb_tx_sequencer
//
// Frames one USB full-speed packet per command: SYNC, PID, optional payload,
// CRC16 and EOP. Bytes are handed one at a time to a downstream byte-load shift
// register; the bit timer reports completion of each byte with byte_done and
// paces the EOP with shift_strobe.
//
// Parameters
//   MAX_PKT_BYTES  largest legal payload (1..255)
//   SIZE_W         width of tx_packet_data_size, 2^SIZE_W > MAX_PKT_BYTES
//   SYNC_BYTE      byte shifted out for SYNC (LSB first)
//
// Ports
//   clk, n_rst            clock, asynchronous active-low reset
//   tx_packet             command: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK,
//                         5 STALL, 6/7 illegal
//   tx_packet_data_size   payload length, sampled when a command is accepted
//   tx_packet_data        head byte of the first-word-fall-through TX buffer
//   tx_abort              terminate the packet currently being framed
//   byte_done             8th bit of the loaded byte has been shifted
//   shift_strobe          one pulse per bit time
//   crc                   final (inverted) CRC16 of the payload
//   data_pts              byte presented to the shift register (registered)
//   load_enable           parallel load strobe
//   get_tx_packet         pop the TX buffer
//   crc_enable            feed tx_packet_data into the CRC generator
//   clear_crc             reset the CRC generator
//   enable_timer          run the bit timer
//   clear_timer           hold the bit timer cleared
//   enc_mode              0 idle J, 1 NRZI data, 2 SE0, 3 J
//   busy                  packet in progress
//   tx_done               one-cycle packet-complete pulse
//   tx_error              one-cycle pulse on rejected command or abort
// -----------------------------------------------------------------------------
module usb_tx_sequencer #(
  parameter int unsigned MAX_PKT_BYTES = 64,
  parameter int unsigned SIZE_W        = 7,
  parameter logic [7:0]  SYNC_BYTE     = 8'h80
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        tx_packet,
  input  logic [SIZE_W-1:0] tx_packet_data_size,
  input  logic [7:0]        tx_packet_data,
  input  logic              tx_abort,
  input  logic              byte_done,
  input  logic              shift_strobe,
  input  logic [15:0]       crc,
  output logic [7:0]        data_pts,
  output logic              load_enable,
  output logic              get_tx_packet,
  output logic              crc_enable,
  output logic              clear_crc,
  output logic              enable_timer,
  output logic              clear_timer,
  output logic [1:0]        enc_mode,
  output logic              busy,
  output logic              tx_done,
  output logic              tx_error
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SYNC_L  = 4'd1,
    S_SYNC    = 4'd2,
    S_PID_L   = 4'd3,
    S_PID     = 4'd4,
    S_DATA_L  = 4'd5,
    S_DATA    = 4'd6,
    S_CRC1_L  = 4'd7,
    S_CRC1    = 4'd8,
    S_CRC2_L  = 4'd9,
    S_CRC2    = 4'd10,
    S_EOP_SE0 = 4'd11,
    S_EOP_J   = 4'd12,
    S_DONE    = 4'd13,
    S_ERR     = 4'd14
  } state_t;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_DATA0 = 3'd1;
  localparam logic [2:0] CMD_DATA1 = 3'd2;
  localparam logic [2:0] CMD_ACK   = 3'd3;
  localparam logic [2:0] CMD_NAK   = 3'd4;
  localparam logic [2:0] CMD_STALL = 3'd5;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_NRZI = 2'd1;
  localparam logic [1:0] ENC_SE0  = 2'd2;
  localparam logic [1:0] ENC_J    = 2'd3;

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_PKT_BYTES);

  // PID byte on the wire: check nibble (complement) in the upper half.
  function automatic logic [7:0] pid_byte(input logic [2:0] cmd);
    logic [3:0] pid;
    case (cmd)
      CMD_DATA0: pid = 4'b0011;
      CMD_DATA1: pid = 4'b1011;
      CMD_ACK:   pid = 4'b0010;
      CMD_NAK:   pid = 4'b1010;
      CMD_STALL: pid = 4'b1110;
      default:   pid = 4'b0000;
    endcase
    return {~pid, pid};
  endfunction

  state_t            state_r, state_n;
  logic [2:0]        cmd_r, cmd_n;
  logic [SIZE_W-1:0] count_r, count_n;
  logic              abort_r, abort_n;
  logic [7:0]        data_pts_r, data_pts_n;
  logic              eop_cnt_r, eop_cnt_n;

  logic              cmd_is_data_s;
  logic              cmd_reject_s;
  logic              cmd_accept_s;
  logic              in_frame_s;
  logic              latched_data_s;

  // Command classification for the IDLE decision.
  always_comb begin
    cmd_is_data_s  = (tx_packet == CMD_DATA0) || (tx_packet == CMD_DATA1);
    cmd_reject_s   = (tx_packet == 3'd6) || (tx_packet == 3'd7) ||
                     (cmd_is_data_s && (tx_packet_data_size > MAX_SIZE));
    cmd_accept_s   = (tx_packet != CMD_NONE) && !cmd_reject_s;
    in_frame_s     = (state_r >= S_SYNC_L) && (state_r <= S_CRC2);
    latched_data_s = (cmd_r == CMD_DATA0) || (cmd_r == CMD_DATA1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= S_IDLE;
      cmd_r      <= CMD_NONE;
      count_r    <= '0;
      abort_r    <= 1'b0;
      data_pts_r <= 8'h00;
      eop_cnt_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      cmd_r      <= cmd_n;
      count_r    <= count_n;
      abort_r    <= abort_n;
      data_pts_r <= data_pts_n;
      eop_cnt_r  <= eop_cnt_n;
    end
  end

  // Next-state logic; data_pts_n is only changed on transitions into a load state.
  always_comb begin
    state_n    = state_r;
    cmd_n      = cmd_r;
    count_n    = count_r;
    abort_n    = abort_r;
    data_pts_n = data_pts_r;
    eop_cnt_n  = 1'b0;

    // Abort takes priority over byte_done anywhere inside the byte stream.
    if (in_frame_s && tx_abort) begin
      state_n = S_EOP_SE0;
      abort_n = 1'b1;
      if (state_r == S_DATA_L) begin
        count_n = count_r - SIZE_W'(1);
      end else begin
        count_n = count_r;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          abort_n = 1'b0;
          if (tx_packet == CMD_NONE) begin
            state_n = S_IDLE;
          end else if (cmd_reject_s) begin
            state_n = S_ERR;
          end else begin
            state_n    = S_SYNC_L;
            cmd_n      = tx_packet;
            count_n    = tx_packet_data_size;
            data_pts_n = SYNC_BYTE;
          end
        end
        S_ERR:    state_n = S_IDLE;
        S_SYNC_L: state_n = S_SYNC;
        S_SYNC: begin
          if (byte_done) begin
            state_n    = S_PID_L;
            data_pts_n = pid_byte(cmd_r);
          end else begin
            state_n = S_SYNC;
          end
        end
        S_PID_L: state_n = S_PID;
        S_PID: begin
          if (!byte_done) begin
            state_n = S_PID;
          end else if (!latched_data_s) begin
            state_n = S_EOP_SE0;
          end else if (count_r == '0) begin
            state_n    = S_CRC1_L;
            data_pts_n = crc[7:0];
          end else begin
            state_n    = S_DATA_L;
            data_pts_n = tx_packet_data;
          end
        end
        S_DATA_L: begin
          state_n = S_DATA;
          count_n = count_r - SIZE_W'(1);
        end
        S_DATA: begin
          if (!byte_done) begin
            state_n = S_DATA;
          end else if (count_r == '0) begin
            state_n    = S_CRC1_L;
            data_pts_n = crc[7:0];
          end else begin
            state_n    = S_DATA_L;
            data_pts_n = tx_packet_data;
          end
        end
        S_CRC1_L: state_n = S_CRC1;
        S_CRC1: begin
          if (byte_done) begin
            state_n    = S_CRC2_L;
            data_pts_n = crc[15:8];
          end else begin
            state_n = S_CRC1;
          end
        end
        S_CRC2_L: state_n = S_CRC2;
        S_CRC2: begin
          if (byte_done) begin
            state_n = S_EOP_SE0;
          end else begin
            state_n = S_CRC2;
          end
        end
        S_EOP_SE0: begin
          // SE0 is held for two bit times; eop_cnt_r marks the first one.
          if (shift_strobe && eop_cnt_r) begin
            state_n = S_EOP_J;
          end else if (shift_strobe) begin
            eop_cnt_n = 1'b1;
          end else begin
            eop_cnt_n = eop_cnt_r;
          end
        end
        S_EOP_J: begin
          if (shift_strobe) begin
            state_n = S_DONE;
          end else begin
            state_n = S_EOP_J;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Moore decode of the strobes from the registered state; clear_crc marks the accept cycle.
  always_comb begin
    load_enable   = 1'b0;
    get_tx_packet = 1'b0;
    crc_enable    = 1'b0;
    clear_crc     = 1'b0;
    enable_timer  = 1'b0;
    clear_timer   = 1'b0;
    enc_mode      = ENC_IDLE;
    busy          = 1'b1;
    tx_done       = 1'b0;
    tx_error      = 1'b0;

    case (state_r)
      S_IDLE: begin
        busy        = 1'b0;
        clear_timer = 1'b1;
        clear_crc   = cmd_accept_s;
      end
      S_ERR: begin
        busy     = 1'b0;
        tx_error = 1'b1;
      end
      S_SYNC_L, S_PID_L, S_CRC1_L, S_CRC2_L: begin
        load_enable  = 1'b1;
        enable_timer = 1'b1;
        enc_mode     = ENC_NRZI;
      end
      S_DATA_L: begin
        load_enable   = 1'b1;
        get_tx_packet = 1'b1;
        crc_enable    = 1'b1;
        enable_timer  = 1'b1;
        enc_mode      = ENC_NRZI;
      end
      S_SYNC, S_PID, S_DATA, S_CRC1, S_CRC2: begin
        enable_timer = 1'b1;
        enc_mode     = ENC_NRZI;
      end
      S_EOP_SE0: enc_mode = ENC_SE0;
      S_EOP_J:   enc_mode = ENC_J;
      S_DONE: begin
        tx_done  = !abort_r;
        tx_error = abort_r;
      end
      default: begin
        busy        = 1'b0;
        clear_timer = 1'b1;
      end
    endcase
  end

  assign data_pts = data_pts_r;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
`timescale 1ns/1ps
module tb_usb_tx_sequencer;
  localparam int MAXP   = 64;
  localparam int SIZE_W = 7;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [2:0]        tx_packet = 3'd0;
  logic [SIZE_W-1:0] tx_packet_data_size = '0;
  logic [7:0]        tx_packet_data = 8'h00;
  logic              tx_abort = 1'b0;
  logic              byte_done = 1'b0;
  logic              shift_strobe = 1'b0;
  logic [15:0]       crc = 16'h0000;
  logic [7:0]        data_pts;
  logic              load_enable, get_tx_packet, crc_enable, clear_crc;
  logic              enable_timer, clear_timer, busy, tx_done, tx_error;
  logic [1:0]        enc_mode;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.MAX_PKT_BYTES(MAXP), .SIZE_W(SIZE_W), .SYNC_BYTE(8'h80)) dut (
    .clk(clk), .n_rst(n_rst), .tx_packet(tx_packet),
    .tx_packet_data_size(tx_packet_data_size), .tx_packet_data(tx_packet_data),
    .tx_abort(tx_abort), .byte_done(byte_done), .shift_strobe(shift_strobe),
    .crc(crc), .data_pts(data_pts), .load_enable(load_enable),
    .get_tx_packet(get_tx_packet), .crc_enable(crc_enable), .clear_crc(clear_crc),
    .enable_timer(enable_timer), .clear_timer(clear_timer), .enc_mode(enc_mode),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  typedef struct {
    bit rejected;
    bit aborted;
    int pops;
  } outcome_t;

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] exp_bytes[$];
  outcome_t   exp_out[$];
  logic [7:0] buf_q[$];
  logic [7:0] fixed_pl[$];
  int pops_seen = 0, crcen_seen = 0, clrcrc_seen = 0, se0_seen = 0, j_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wire-level PID bytes as listed for each command.
  function automatic logic [7:0] pid_of(input int cmd);
    case (cmd)
      1: return 8'hC3;
      2: return 8'h4B;
      3: return 8'hD2;
      4: return 8'h5A;
      5: return 8'h1E;
      default: return 8'h00;
    endcase
  endfunction

  task automatic clear_counters();
    pops_seen = 0; crcen_seen = 0; clrcrc_seen = 0; se0_seen = 0; j_seen = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {data_pts, load_enable, get_tx_packet, crc_enable, clear_crc, enable_timer,
                 clear_timer, enc_mode, busy, tx_done, tx_error},
                {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("reset_outputs");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    exp_bytes.delete(); exp_out.delete(); buf_q.delete();
    tx_packet_data = 8'h00;
    clear_counters();
    n_rst = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  // Wait until every expected completion has been observed; a timeout counts as a miscompare.
  task automatic wait_idle();
    int t = 0;
    while (exp_out.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_out.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL completion_timeout: got no tx_done/tx_error expected one within 3000 cycles");
      do_reset();
    end
  endtask

  // Issue one command; the reference model pushes its expected loads and completion first.
  task automatic issue(input int cmd, input int size, input logic [15:0] crc_v,
                       input int abort_at, input bit use_fixed);
    bit         legal;
    bit         is_data;
    int         n;
    logic [7:0] pl[$];
    wait_idle();
    buf_q.delete();
    is_data = (cmd == 1 || cmd == 2);
    legal   = (cmd >= 1 && cmd <= 5) && !(is_data && size > MAXP);
    if (!legal) begin
      exp_out.push_back('{rejected: 1'b1, aborted: 1'b0, pops: 0});
    end else begin
      if (is_data) begin
        for (int i = 0; i < size; i++) begin
          if (use_fixed) pl.push_back(fixed_pl[i]);
          else pl.push_back(8'($urandom_range(0, 255)));
          buf_q.push_back(pl[i]);
        end
      end
      n = (is_data) ? ((abort_at != 0) ? abort_at : size) : 0;
      exp_bytes.push_back(8'h80);
      exp_bytes.push_back(pid_of(cmd));
      for (int i = 0; i < n; i++) exp_bytes.push_back(pl[i]);
      if (is_data && abort_at == 0) begin
        exp_bytes.push_back(crc_v[7:0]);
        exp_bytes.push_back(crc_v[15:8]);
      end
      exp_out.push_back('{rejected: 1'b0, aborted: (abort_at != 0), pops: n});
    end
    @(posedge clk); #1;
    crc                 = crc_v;
    tx_packet_data      = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
    tx_packet           = 3'(cmd);
    tx_packet_data_size = SIZE_W'(size);
    @(posedge clk); #1;
    tx_packet           = 3'd0;
    tx_packet_data_size = SIZE_W'($urandom_range(0, 127));
    if (abort_at != 0) begin
      int seen = 0;
      int t = 0;
      while (seen < abort_at && t < 3000) begin
        @(negedge clk);
        if (get_tx_packet) seen++;
        t++;
      end
      @(posedge clk); #1;
      tx_abort = 1'b1;
      @(posedge clk); #1;
      tx_abort = 1'b0;
    end
  endtask

  // Bit-timer model: pulse byte_done a few cycles after each load.
  initial begin
    forever begin
      @(negedge clk);
      if (load_enable && n_rst) begin
        @(posedge clk); #1;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        byte_done = 1'b1;
        @(posedge clk); #1;
        byte_done = 1'b0;
      end
    end
  end

  // Random bit-time strobes.
  initial begin
    forever begin
      @(posedge clk); #1;
      shift_strobe = ($urandom_range(0, 2) == 0);
    end
  end

  // First-word-fall-through buffer: pop on get_tx_packet.
  initial begin
    forever begin
      @(negedge clk);
      if (get_tx_packet && n_rst) begin
        @(posedge clk); #1;
        if (buf_q.size() != 0) void'(buf_q.pop_front());
        tx_packet_data = (buf_q.size() != 0) ? buf_q[0] : 8'h00;
      end
    end
  end

  // Monitor: compares every observed load and completion against the scoreboard.
  initial begin
    outcome_t o;
    forever begin
      @(negedge clk);
      if (!n_rst) continue;
      if (load_enable) begin
        if (exp_bytes.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_load: got data_pts %0h expected no load", data_pts);
        end else begin
          check("load_byte", data_pts, exp_bytes.pop_front());
        end
        check("load_ctrl", {enable_timer, clear_timer, enc_mode, busy}, {1'b1, 1'b0, 2'd1, 1'b1});
      end
      if (get_tx_packet) begin
        pops_seen++;
        check("pop_data", data_pts, tx_packet_data);
      end
      if (crc_enable) crcen_seen++;
      if (clear_crc) clrcrc_seen++;
      if (enc_mode == 2'd2 && shift_strobe) se0_seen++;
      if (enc_mode == 2'd3 && shift_strobe) j_seen++;
      if (tx_done || tx_error) begin
        if (exp_out.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_end: got done=%0b error=%0b expected none", tx_done, tx_error);
        end else begin
          o = exp_out.pop_front();
          check("end_kind", {tx_done, tx_error},
                {!(o.rejected || o.aborted), (o.rejected || o.aborted)});
          check("busy_at_end", busy, !o.rejected);
          check("pops", pops_seen, o.pops);
          check("crc_enables", crcen_seen, o.pops);
          check("clear_crc", clrcrc_seen, o.rejected ? 0 : 1);
          check("eop_se0_strobes", se0_seen, o.rejected ? 0 : 2);
          check("eop_j_strobes", j_seen, o.rejected ? 0 : 1);
          check("loads_left", exp_bytes.size(), 0);
        end
        clear_counters();
      end
    end
  end

  // Global guard against a stuck run.
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cmd, size, ab;
    #1;
    check_reset_outputs("reset_initial");
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // DATA0, 3 bytes, known payload and CRC
    fixed_pl = '{8'h11, 8'h22, 8'h33};
    issue(1, 3, 16'hABCD, 0, 1'b1);
    // handshake
    issue(3, 0, 16'h1234, 0, 1'b0);
    // zero-length DATA1
    issue(2, 0, 16'h0000, 0, 1'b0);
    // rejections
    issue(1, 65, 16'h5555, 0, 1'b0);
    issue(7, 0, 16'h5555, 0, 1'b0);
    issue(6, 3, 16'h5555, 0, 1'b0);
    // abort on second of four bytes
    issue(1, 4, 16'h7777, 2, 1'b0);
    // boundary: exactly max payload
    issue(2, MAXP, 16'hBEEF, 0, 1'b0);
    issue(4, 0, 16'h0000, 0, 1'b0);
    issue(5, 0, 16'h0000, 0, 1'b0);

    // reset during CRC1
    issue(1, 2, 16'hC0DE, 0, 1'b0);
    begin
      int loads = 0;
      int t = 0;
      while (loads < 5 && t < 3000) begin
        @(negedge clk);
        if (load_enable) loads++;
        t++;
      end
      check("loads_before_reset", loads, 5);
    end
    do_reset();
    issue(1, 3, 16'h1357, 0, 1'b0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      cmd  = $urandom_range(1, 8);
      if (cmd == 8) cmd = $urandom_range(1, 2);
      size = ($urandom_range(0, 9) == 0) ? $urandom_range(65, 127) : $urandom_range(0, MAXP);
      ab   = 0;
      if ((cmd == 1 || cmd == 2) && size >= 1 && size <= MAXP && $urandom_range(0, 4) == 0)
        ab = $urandom_range(1, size);
      issue(cmd, size, 16'($urandom_range(0, 65535)), ab, 1'b0);
    end
    wait_idle();
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
